// File: rtl/pc_ras_pkg.sv
// Shared definitions for the pc_ras program counter and its return-address stack.
package pc_ras_pkg;

  localparam int unsigned OP_W = 3;

  typedef enum logic [OP_W-1:0] {
    NOP  = 3'd0,
    INC  = 3'd1,
    ADD  = 3'd2,
    SUB  = 3'd3,
    JMP  = 3'd4,
    CALL = 3'd5,
    RET  = 3'd6,
    RSVD = 3'd7
  } op_e;

endpackage

// File: rtl/pc_ras_if.sv
// Fetch-stage controller <-> pc_ras bundle: op/offset in, pc/stack/status out.
interface pc_ras_if #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 8
);
  import pc_ras_pkg::*;

  op_e                          op;
  logic [WIDTH-1:0]             offset;
  logic [WIDTH-1:0]             pc;
  logic [WIDTH-1:0]             top;
  logic [$clog2(DEPTH+1)-1:0]   count;
  logic                         wrap;
  logic                         ovf;
  logic                         unf;

  modport master (
    output op, offset,
    input  pc, top, count, wrap, ovf, unf
  );

  modport slave (
    input  op, offset,
    output pc, top, count, wrap, ovf, unf
  );

endinterface

// File: rtl/pc_ras_stack.sv
// Strict LIFO of return addresses; push when full and pop when empty are ignored.
module pc_ras_stack #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          push,
  input  logic                          pop,
  input  logic [WIDTH-1:0]              din,
  output logic [WIDTH-1:0]              top,
  output logic [$clog2(DEPTH+1)-1:0]    count,
  output logic                          full,
  output logic                          empty
);

  localparam int unsigned CW = $clog2(DEPTH+1);
  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  // Storage is sized to a power of two so the address width matches exactly.
  logic [WIDTH-1:0] mem [2**AW];
  logic [CW-1:0]    count_q;
  logic [CW-1:0]    rd_idx;

  assign full   = (count_q == CW'(DEPTH));
  assign empty  = (count_q == '0);
  assign rd_idx = count_q - CW'(1);
  assign top    = empty ? '0 : mem[rd_idx[AW-1:0]];
  assign count  = count_q;

  always_ff @(posedge clk) begin
    if (push && !full) begin
      mem[count_q[AW-1:0]] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      count_q <= '0;
    end else if (push && !full) begin
      count_q <= count_q + CW'(1);
    end else if (pop && !empty) begin
      count_q <= count_q - CW'(1);
    end
  end

endmodule

// File: rtl/pc_ras.sv
// Fetch-stage program counter with integrated return-address stack and registered status pulses.
module pc_ras
  import pc_ras_pkg::*;
#(
  parameter int unsigned     WIDTH     = 16,
  parameter int unsigned     DEPTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VEC = '0
) (
  input  logic        clk,
  input  logic        reset,
  pc_ras_if.slave     bus
);

  logic [WIDTH-1:0] pc_q;
  logic [WIDTH-1:0] pc_n;
  logic             wrap_q, ovf_q, unf_q;
  logic             wrap_n, ovf_n, unf_n;
  logic [WIDTH-1:0] addend;
  logic             do_sub;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] stk_top;
  logic             stk_full, stk_empty;

  pc_ras_stack #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_stack (
    .clk   (clk),
    .reset (reset),
    .push  (bus.op == CALL),
    .pop   (bus.op == RET),
    .din   (sum[WIDTH-1:0]),
    .top   (stk_top),
    .count (bus.count),
    .full  (stk_full),
    .empty (stk_empty)
  );

  // One shared adder: also produces the CALL return address pc+1, whose carry is discarded.
  always_comb begin
    addend = '0;
    do_sub = 1'b0;
    case (bus.op)
      INC, CALL: addend = WIDTH'(1);
      ADD:       addend = bus.offset;
      SUB: begin
        addend = bus.offset;
        do_sub = 1'b1;
      end
      default:   addend = '0;
    endcase
    sum = do_sub ? ({1'b0, pc_q} - {1'b0, addend})
                 : ({1'b0, pc_q} + {1'b0, addend});
  end

  always_comb begin
    pc_n   = pc_q;
    wrap_n = 1'b0;
    ovf_n  = 1'b0;
    unf_n  = 1'b0;
    case (bus.op)
      INC, ADD, SUB: begin
        pc_n   = sum[WIDTH-1:0];
        wrap_n = sum[WIDTH];
      end
      JMP:  pc_n = bus.offset;
      CALL: begin
        pc_n  = bus.offset;
        ovf_n = stk_full;
      end
      RET: begin
        pc_n  = stk_empty ? pc_q : stk_top;
        unf_n = stk_empty;
      end
      default: pc_n = pc_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      pc_q   <= RESET_VEC;
      wrap_q <= 1'b0;
      ovf_q  <= 1'b0;
      unf_q  <= 1'b0;
    end else begin
      pc_q   <= pc_n;
      wrap_q <= wrap_n;
      ovf_q  <= ovf_n;
      unf_q  <= unf_n;
    end
  end

  assign bus.pc   = pc_q;
  assign bus.top  = stk_top;
  assign bus.wrap = wrap_q;
  assign bus.ovf  = ovf_q;
  assign bus.unf  = unf_q;

endmodule

// File: tb/tb_pc_ras.sv
// Directed bench for pc_ras: arithmetic, wrap, nested calls, overflow/underflow and mid-sequence reset.
module tb_pc_ras;
  import pc_ras_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int checks = 0;
  int errors = 0;

  pc_ras_if #(.WIDTH(16), .DEPTH(8)) bus ();

  pc_ras #(
    .WIDTH     (16),
    .DEPTH     (8),
    .RESET_VEC (16'h0100)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic step(input op_e o, input logic [15:0] off);
    bus.op     = o;
    bus.offset = off;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b0;
    step(INC, 16'h0000);
    step(INC, 16'h0000);
    checks++; if (bus.pc !== 16'h0100) begin errors++; $display("FAIL reset_pc got %h exp 0100", bus.pc); end
    checks++; if (bus.count !== 4'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", bus.count); end
    checks++; if (bus.top !== 16'h0000) begin errors++; $display("FAIL reset_top got %h exp 0000", bus.top); end
    checks++; if ({bus.wrap, bus.ovf, bus.unf} !== 3'b000) begin errors++; $display("FAIL reset_flags got %b exp 000", {bus.wrap, bus.ovf, bus.unf}); end
    reset = 1'b1;
  endtask

  task automatic test_arith;
    for (int i = 0; i < 3; i++) begin
      step(INC, 16'h0000);
      checks++; if (bus.wrap !== 1'b0) begin errors++; $display("FAIL arith_inc_wrap got %b exp 0", bus.wrap); end
    end
    checks++; if (bus.pc !== 16'h0103) begin errors++; $display("FAIL arith_inc got %h exp 0103", bus.pc); end
    step(ADD, 16'h0010);
    checks++; if (bus.pc !== 16'h0113 || bus.wrap !== 1'b0) begin errors++; $display("FAIL arith_add got %h/%b exp 0113/0", bus.pc, bus.wrap); end
    step(SUB, 16'h0014);
    checks++; if (bus.pc !== 16'h00FF || bus.wrap !== 1'b0) begin errors++; $display("FAIL arith_sub got %h/%b exp 00ff/0", bus.pc, bus.wrap); end
  endtask

  task automatic test_wrap;
    step(JMP, 16'hFFFF);
    checks++; if (bus.pc !== 16'hFFFF || bus.wrap !== 1'b0) begin errors++; $display("FAIL wrap_jmp got %h/%b exp ffff/0", bus.pc, bus.wrap); end
    step(INC, 16'h0000);
    checks++; if (bus.pc !== 16'h0000 || bus.wrap !== 1'b1) begin errors++; $display("FAIL wrap_inc got %h/%b exp 0000/1", bus.pc, bus.wrap); end
    step(NOP, 16'h0000);
    checks++; if (bus.pc !== 16'h0000 || bus.wrap !== 1'b0) begin errors++; $display("FAIL wrap_pulse got %h/%b exp 0000/0", bus.pc, bus.wrap); end
    step(SUB, 16'h0001);
    checks++; if (bus.pc !== 16'hFFFF || bus.wrap !== 1'b1) begin errors++; $display("FAIL wrap_sub got %h/%b exp ffff/1", bus.pc, bus.wrap); end
    step(ADD, 16'h0002);
    checks++; if (bus.pc !== 16'h0001 || bus.wrap !== 1'b1) begin errors++; $display("FAIL wrap_add got %h/%b exp 0001/1", bus.pc, bus.wrap); end
    step(JMP, 16'hFFFF);
    step(CALL, 16'h0020);
    checks++; if (bus.pc !== 16'h0020 || bus.top !== 16'h0000 || bus.count !== 4'd1 || bus.wrap !== 1'b0)
      begin errors++; $display("FAIL wrap_call got pc %h top %h cnt %0d wrap %b exp 0020 0000 1 0", bus.pc, bus.top, bus.count, bus.wrap); end
    step(RET, 16'h0000);
    checks++; if (bus.pc !== 16'h0000 || bus.count !== 4'd0) begin errors++; $display("FAIL wrap_ret got %h/%0d exp 0000/0", bus.pc, bus.count); end
  endtask

  task automatic test_calls;
    step(JMP, 16'h0010);
    step(CALL, 16'h0200);
    checks++; if (bus.pc !== 16'h0200 || bus.top !== 16'h0011 || bus.count !== 4'd1)
      begin errors++; $display("FAIL call1 got pc %h top %h cnt %0d exp 0200 0011 1", bus.pc, bus.top, bus.count); end
    step(CALL, 16'h0300);
    checks++; if (bus.pc !== 16'h0300 || bus.top !== 16'h0201 || bus.count !== 4'd2)
      begin errors++; $display("FAIL call2 got pc %h top %h cnt %0d exp 0300 0201 2", bus.pc, bus.top, bus.count); end
    step(RET, 16'h0000);
    checks++; if (bus.pc !== 16'h0201 || bus.top !== 16'h0011 || bus.count !== 4'd1)
      begin errors++; $display("FAIL ret1 got pc %h top %h cnt %0d exp 0201 0011 1", bus.pc, bus.top, bus.count); end
    step(RET, 16'h0000);
    checks++; if (bus.pc !== 16'h0011 || bus.top !== 16'h0000 || bus.count !== 4'd0 || bus.unf !== 1'b0)
      begin errors++; $display("FAIL ret2 got pc %h top %h cnt %0d unf %b exp 0011 0000 0 0", bus.pc, bus.top, bus.count, bus.unf); end
  endtask

  task automatic test_overflow;
    logic [15:0] ret_addr [8];
    logic [15:0] tgt;
    // pc is 0x0011 here, so the first return address is 0x0012
    for (int i = 0; i < 9; i++) begin
      tgt = 16'h1000 + 16'(i * 16);
      if (i < 8) ret_addr[i] = (i == 0) ? 16'h0012 : 16'h1000 + 16'((i - 1) * 16) + 16'h0001;
      step(CALL, tgt);
      checks++; if (bus.ovf !== (i == 8)) begin errors++; $display("FAIL ovf_call%0d got %b exp %b", i, bus.ovf, (i == 8)); end
    end
    checks++; if (bus.pc !== 16'h1080 || bus.count !== 4'd8 || bus.top !== 16'h1061)
      begin errors++; $display("FAIL ovf_state got pc %h cnt %0d top %h exp 1080 8 1061", bus.pc, bus.count, bus.top); end
    for (int j = 7; j >= 0; j--) begin
      step(RET, 16'h0000);
      checks++; if (bus.pc !== ret_addr[j] || bus.count !== 4'(j) || bus.ovf !== 1'b0 || bus.unf !== 1'b0)
        begin errors++; $display("FAIL ovf_unwind%0d got pc %h cnt %0d exp %h %0d", j, bus.pc, bus.count, ret_addr[j], j); end
    end
  endtask

  task automatic test_underflow_rsvd;
    step(RET, 16'h0000);
    checks++; if (bus.pc !== 16'h0012 || bus.unf !== 1'b1 || bus.count !== 4'd0)
      begin errors++; $display("FAIL unf got pc %h unf %b cnt %0d exp 0012 1 0", bus.pc, bus.unf, bus.count); end
    step(RET, 16'h0000);
    checks++; if (bus.pc !== 16'h0012 || bus.unf !== 1'b1) begin errors++; $display("FAIL unf_hold got %h/%b exp 0012/1", bus.pc, bus.unf); end
    step(NOP, 16'h0000);
    checks++; if (bus.unf !== 1'b0) begin errors++; $display("FAIL unf_pulse got %b exp 0", bus.unf); end
    step(CALL, 16'h0040);
    step(RSVD, 16'h1234);
    checks++; if (bus.pc !== 16'h0040 || bus.count !== 4'd1 || bus.top !== 16'h0013 || {bus.wrap, bus.ovf, bus.unf} !== 3'b000)
      begin errors++; $display("FAIL rsvd got pc %h cnt %0d top %h flags %b exp 0040 1 0013 000", bus.pc, bus.count, bus.top, {bus.wrap, bus.ovf, bus.unf}); end
    step(RET, 16'h0000);
    checks++; if (bus.pc !== 16'h0013 || bus.count !== 4'd0) begin errors++; $display("FAIL rsvd_ret got %h/%0d exp 0013/0", bus.pc, bus.count); end
  endtask

  task automatic test_reset_mid;
    step(CALL, 16'h0400);
    step(CALL, 16'h0500);
    step(CALL, 16'h0600);
    checks++; if (bus.count !== 4'd3 || bus.top !== 16'h0501) begin errors++; $display("FAIL mid_pre got cnt %0d top %h exp 3 0501", bus.count, bus.top); end
    reset = 1'b0;
    step(CALL, 16'h0700);
    reset = 1'b1;
    checks++; if (bus.pc !== 16'h0100 || bus.count !== 4'd0 || bus.top !== 16'h0000 || {bus.wrap, bus.ovf, bus.unf} !== 3'b000)
      begin errors++; $display("FAIL mid_reset got pc %h cnt %0d top %h flags %b exp 0100 0 0000 000", bus.pc, bus.count, bus.top, {bus.wrap, bus.ovf, bus.unf}); end
    step(RET, 16'h0000);
    checks++; if (bus.pc !== 16'h0100 || bus.unf !== 1'b1) begin errors++; $display("FAIL mid_ret got %h/%b exp 0100/1", bus.pc, bus.unf); end
  endtask

  initial begin
    reset      = 1'b0;
    bus.op     = NOP;
    bus.offset = 16'h0000;
    test_reset();
    test_arith();
    test_wrap();
    test_calls();
    test_overflow();
    test_underflow_rsvd();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pc_ras.md
# pc_ras

Parametrised program counter with an integrated return-address stack (RAS). It extends the 16-bit inc/add/sub counter with configurable width, absolute jump, call/return and registered wrap/overflow/underflow status. It sits in the fetch stage: the controller issues one operation code per cycle, and `pc` drives the instruction-memory address.

## Interface
Parameters:
- `WIDTH`, 16: PC, offset and stack-entry width in bits; must be at least 2.
- `DEPTH`, 8: number of RAS entries; must be at least 1.
- `RESET_VEC`, 0: PC value loaded on reset; `WIDTH` bits wide.

Ports:
- `clk`, in, 1: single clock. All state updates on the rising edge.
- `reset`, in, 1: synchronous, active-low. Sampled on the rising edge of `clk`.
- `op`, in, 3: operation code, sampled every cycle.
- `offset`, in, `WIDTH`: relative offset for ADD/SUB, absolute target for JMP/CALL.
- `pc`, out, `WIDTH`: current program counter (registered).
- `top`, out, `WIDTH`: current top-of-stack entry; 0 when the stack is empty.
- `count`, out, `$clog2(DEPTH+1)`: number of valid RAS entries.
- `wrap`, out, 1: one-cycle pulse when the last INC/ADD produced a carry-out or the last SUB produced a borrow.
- `ovf`, out, 1: one-cycle pulse when a CALL found the stack full.
- `unf`, out, 1: one-cycle pulse when a RET found the stack empty.

## Operation
Operation codes:
- NOP=0: hold `pc`.
- INC=1: `pc <= pc+1`.
- ADD=2: `pc <= pc+offset`.
- SUB=3: `pc <= pc-offset`.
- JMP=4: `pc <= offset`.
- CALL=5: push `pc+1`, then `pc <= offset`.
- RET=6: `pc <= top`, then pop.
- 7: reserved; behaves exactly as NOP.

Arithmetic and width rules:
- All arithmetic is modulo 2^`WIDTH`.
- The CALL return address `pc+1` wraps silently. It never asserts `wrap`.
- `wrap` is asserted only for INC, ADD and SUB. It is 0 for all other ops.

Boundary cases:
- CALL with `count==DEPTH`: no push, and `count` and stack contents are unchanged. `pc <= offset` still occurs, and `ovf` pulses.
- RET with `count==0`: `pc` holds, `count` stays 0, and `unf` pulses.
- Stack is strict LIFO with no circular overwrite.
- Stack storage needs no reset. After reset, only `count` defines which entries are valid.

Reset:
- While `reset==0` at a clock edge: `pc<=RESET_VEC`, `count<=0`, `wrap/ovf/unf<=0`, and `top` reads 0.
- Reset overrides any concurrent `op`.
- Reset asserted mid-sequence, for example between nested CALLs, discards all stack entries.

## Timing
- Latency is one cycle: `op` sampled at edge N is reflected on `pc`, `count`, `top` and the flags after edge N.
- An op can be issued every cycle. There is no handshake and no stall.
- Back-to-back CALL then RET returns to the pre-CALL `pc+1` at the second edge.
- Back-to-back RET then RET pops two levels on consecutive cycles.
- `top` is a combinational read of the stack entry at index `count-1`, so it changes in the same cycle as `count`.
- Flags are registered, and each pulses for exactly one cycle per offending op. A repeated offending op on consecutive cycles holds the flag high.

## Structure
- Shared package `pc_ras_pkg` holds:
  - the `op` enum: NOP, INC, ADD, SUB, JMP, CALL, RET, RSVD;
  - the width constant for `op` (3).
- Sub-module `pc_ras_stack` is a parametrised LIFO (`WIDTH`, `DEPTH`):
  - inputs `push`, `pop`, `din`;
  - outputs `top`, `count`, `full`, `empty`;
  - it ignores a push when full and a pop when empty.
- The top level holds:
  - the PC register;
  - a single `WIDTH+1`-bit adder/subtractor for INC/ADD/SUB;
  - the next-PC mux;
  - the flag registers.
- Expected size is about 200 RTL lines in total.

## Test plan
- **Reset and arithmetic:** apply reset with `RESET_VEC=16'h0100`, then INC ×3 → `pc=0x0103`. Then ADD `offset=0x0010` → `0x0113`. Then SUB `0x0014` → `0x00FF`. `wrap` stays 0 throughout.
- **Wrap-around:** with `pc=0xFFFF`, INC → `pc=0x0000` and `wrap=1` for one cycle. Then, from `pc=0x0000`, SUB 1 → `pc=0xFFFF` and `wrap=1`.
- **Nested calls:** from `pc=0x0010`, CALL `0x0200` → `pc=0x0200`, `top=0x0011`, `count=1`. CALL `0x0300` → `top=0x0201`, `count=2`. RET → `pc=0x0201`. RET → `pc=0x0011`, `count=0`, `top=0`.
- **Overflow:** with `DEPTH=8`, issue 9 consecutive CALLs → `count=8`, `ovf=1` only on the 9th, and `pc` equals the 9th target. Then 8 RETs unwind in exact reverse order, with no corruption from the dropped push.
- **Underflow and reserved op:** RET with `count=0` → `pc` unchanged, `unf=1` for one cycle. Op 7 → no state change and all flags 0.
- **Reset mid-operation:** after 3 CALLs, assert `reset` for one edge while `op=CALL` → `pc=RESET_VEC`, `count=0`, `top=0`, all flags 0. The next RET → `unf=1`.
